// File: rtl/tuple_pkg.sv
// tuple_pkg: shared constants and types for the delay_3 tuple pipeline and its result buffer
package tuple_pkg;
  localparam int TUPLE_LATENCY = 3;
  localparam int RESULT_WIDTH = 8;
  localparam int RESULT_FIFO_DEPTH = 4;
  typedef logic [RESULT_WIDTH-1:0] result_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: first-word fall-through FIFO with separate occupancy so full and empty differ
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = push ? nxt(wr_q) : wr_q;
    rd_d = pop ? nxt(rd_q) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[rd_q];
  assign valid = count_q != '0;
  assign count = count_q;
endmodule

// File: rtl/tuple_result_buffer.sv
// tuple_result_buffer: tags fixed-latency pipeline issues, captures results, credit-throttles upstream
module tuple_result_buffer import tuple_pkg::*; #(
  parameter int LATENCY = TUPLE_LATENCY,
  parameter int DEPTH = RESULT_FIFO_DEPTH,
  parameter int WIDTH = RESULT_WIDTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             _i_clk,
  input  logic             _i_rst_n,
  input  logic             _i_issue_valid,
  output logic             _o_issue_ready,
  input  logic [WIDTH-1:0] _i_result,
  output logic             _o_out_valid,
  input  logic             _i_out_ready,
  output logic [WIDTH-1:0] _o_out_data,
  output logic [CW-1:0]    _o_count
);
  logic [LATENCY-1:0] tag_q, tag_d;
  logic accept, arrive, pop;
  logic [CW-1:0] inflight, credits;
  // Credits use registered state only, so a pop frees its slot one edge later
  always_comb begin
    accept = _i_issue_valid & _o_issue_ready;
    arrive = tag_q[LATENCY-1];
    tag_d = LATENCY'({tag_q, accept});
    inflight = CW'($countones(tag_q));
    credits = CW'(DEPTH) - _o_count - inflight;
    _o_issue_ready = credits != '0;
    pop = _o_out_valid & _i_out_ready;
  end
  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) tag_q <= '0;
    else tag_q <= tag_d;
  end
  result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk(_i_clk),
    .rst_n(_i_rst_n),
    .push(arrive),
    .push_data(_i_result),
    .pop(pop),
    .head(_o_out_data),
    .valid(_o_out_valid),
    .count(_o_count)
  );
endmodule

// File: tb/tb_tuple_result_buffer.sv
// tb_tuple_result_buffer: scoreboard bench with a delay_3 model driving results at arrival edges
module tb_tuple_result_buffer;
  import tuple_pkg::*;
  logic clk = 0, rst_n = 0, issue_valid = 0, issue_ready, out_valid, out_ready = 0;
  result_t result = '0, out_data;
  logic [2:0] count;
  logic [2:0] m_tag = '0;
  result_t m_val [3] = '{default: '0};
  result_t exp_q [$];
  result_t ival = '0, junk = '0;
  logic acc_l = 0;
  int checks = 0, errors = 0, npop = 0;

  tuple_result_buffer dut (
    ._i_clk(clk), ._i_rst_n(rst_n), ._i_issue_valid(issue_valid), ._o_issue_ready(issue_ready),
    ._i_result(result), ._o_out_valid(out_valid), ._i_out_ready(out_ready),
    ._o_out_data(out_data), ._o_count(count)
  );
  always #5 clk = ~clk;

  task automatic tick(input logic iv, input logic rdy);
    logic arr, acc, pop;
    int credit;
    result_t d;
    arr = m_tag[2];
    issue_valid = iv;
    out_ready = rdy;
    result = arr ? m_val[2] : junk;
    #1;
    credit = RESULT_FIFO_DEPTH - int'(exp_q.size()) - $countones(m_tag);
    acc = iv && issue_ready;
    pop = out_valid && rdy;
    checks++;
    if (issue_ready !== (credit > 0)) begin errors++; $display("FAIL issue_ready: got %b want %b", issue_ready, credit > 0); end
    checks++;
    if (count !== 3'(exp_q.size())) begin errors++; $display("FAIL count: got %0d want %0d", count, exp_q.size()); end
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0); end
    if (pop) begin
      checks++;
      npop++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL pop_empty: got data %h want no output", out_data); end
      else begin
        d = exp_q.pop_front();
        if (out_data !== d) begin errors++; $display("FAIL out_data: got %h want %h", out_data, d); end
      end
    end
    checks++;
    if (arr && exp_q.size() >= RESULT_FIFO_DEPTH) begin errors++; $display("FAIL overflow: got push at occupancy %0d want < %0d", exp_q.size(), RESULT_FIFO_DEPTH); end
    if (arr) exp_q.push_back(m_val[2]);
    m_val[2] = m_val[1];
    m_val[1] = m_val[0];
    m_val[0] = ival;
    m_tag = {m_tag[1:0], acc};
    if (acc) ival++;
    acc_l = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: got ready=%b valid=%b count=%0d data=%h want 1 0 0 00", issue_ready, out_valid, count, out_data);
    end
    rst_n = 1;
  endtask

  task automatic test_single();
    int p0 = npop;
    ival = 8'h01;
    junk = 8'h00;
    tick(1, 1);
    tick(0, 1);
    tick(0, 1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid %b want 0", out_valid); end
    tick(0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin errors++; $display("FAIL single_latency: got valid=%b data=%h want 1 01", out_valid, out_data); end
    repeat (4) tick(0, 1);
    checks++;
    if (npop - p0 !== 1) begin errors++; $display("FAIL single_count: got %0d outputs want 1", npop - p0); end
  endtask

  task automatic test_stream();
    int p0 = npop;
    ival = 8'h10;
    for (int i = 0; i < 60; i++) tick(ival < 8'h20, 1);
    checks++;
    if (npop - p0 !== 16 || ival !== 8'h20) begin errors++; $display("FAIL stream: got %0d outputs, next %h want 16, 20", npop - p0, ival); end
  endtask

  task automatic test_backpressure();
    int acc_n = 0, p0 = npop;
    ival = 8'h20;
    for (int i = 0; i < 8; i++) begin tick(1, 0); acc_n += int'(acc_l); end
    checks++;
    if (acc_n !== 4 || count !== 3'd4 || issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_fill: got accepted=%0d count=%0d ready=%b want 4 4 0", acc_n, count, issue_ready);
    end
    tick(0, 1);
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL backpressure_credit: got ready %b want 1", issue_ready); end
    repeat (6) tick(0, 1);
    checks++;
    if (npop - p0 !== 4) begin errors++; $display("FAIL backpressure_drain: got %0d outputs want 4", npop - p0); end
  endtask

  task automatic test_push_pop_same_edge();
    ival = 8'h30;
    repeat (4) tick(1, 0);
    repeat (3) tick(0, 0);
    tick(0, 1);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    checks++;
    if (count !== 3'd3 || issue_ready !== 1'b0) begin errors++; $display("FAIL pushpop_pre: got count=%0d ready=%b want 3 0", count, issue_ready); end
    tick(0, 1);
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL pushpop_count: got %0d want 3", count); end
    repeat (6) tick(0, 1);
  endtask

  task automatic test_midflight_reset();
    int p0;
    ival = 8'h40;
    junk = 8'h77;
    repeat (4) tick(1, 0);
    #1 rst_n = 0;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got ready=%b valid=%b count=%0d data=%h want 1 0 0 00", issue_ready, out_valid, count, out_data);
    end
    rst_n = 1;
    m_tag = '0;
    exp_q.delete();
    p0 = npop;
    for (int i = 0; i < 6; i++) begin m_val[2] = 8'h77; tick(0, 1); end
    checks++;
    if (npop - p0 !== 0 || count !== 3'd0) begin errors++; $display("FAIL late_capture: got outputs=%0d count=%0d want 0 0", npop - p0, count); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_stream();
    test_backpressure();
    test_push_pop_same_edge();
    test_midflight_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
